// File: rtl/quant_zigzag.sv
// quant_zigzag: per-row reciprocal quantizer feeding a double-buffered
// 8x8 block store that is read out in JPEG zigzag order.
module quant_zigzag #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8*IN_W-1:0] in_row,
    input  logic              qt_we,
    input  logic [5:0]        qt_addr,
    input  logic [15:0]       qt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [5:0]        out_idx,
    output logic              out_last
);
    localparam int PW = IN_W + 17;
    localparam logic [OUT_W-1:0] QMIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] QMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [PW-1:0] HALF = PW'(32768);
    localparam logic [PW-1:0] LIM = PW'(2**(OUT_W-1));

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [15:0]      qt  [64];
    logic [OUT_W-1:0] mem [2][64];
    logic [OUT_W-1:0] q   [8];
    logic [1:0]       full;
    logic             wb;
    logic             rb;
    logic [2:0]       row;
    logic [5:0]       k;
    logic             acc;
    logic             rd;
    logic             rd_done;

    // Round half away from zero on the magnitude, then clamp.
    function automatic logic [OUT_W-1:0] quant(
        input logic signed [IN_W-1:0] c,
        input logic [15:0]            r
    );
        logic signed [PW-1:0] p;
        logic [PW-1:0]        mag;
        logic [PW-1:0]        qm;
        logic [PW-1:0]        nq;
        logic [OUT_W-1:0]     res;
        p   = PW'(c) * PW'($signed({1'b0, r}));
        mag = p[PW-1] ? $unsigned(-p) : $unsigned(p);
        qm  = (mag + HALF) >> 16;
        nq  = -qm;
        if (p[PW-1])
            res = (qm >= LIM) ? QMIN : nq[OUT_W-1:0];
        else
            res = (qm > LIM - PW'(1)) ? QMAX : qm[OUT_W-1:0];
        return res;
    endfunction

    always_comb begin
        for (int c = 0; c < 8; c++)
            q[c] = quant(in_row[c*IN_W +: IN_W], qt[{row, 3'(c)}]);
    end

    assign in_ready  = !full[wb];
    assign out_valid = full[rb];
    assign acc       = in_valid && in_ready;
    assign rd        = out_valid && out_ready;
    assign rd_done   = rd && (k == 6'd63);
    assign out_data  = out_valid ? mem[rb][ZZ[k]] : '0;
    assign out_idx   = k;
    assign out_last  = out_valid && (k == 6'd63);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++)
                qt[i] <= 16'd4096;
        end else if (qt_we) begin
            qt[qt_addr] <= qt_data;
        end
    end

    // Bank contents need no reset: the full flags gate every read.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int c = 0; c < 8; c++)
                mem[wb][{row, 3'(c)}] <= q[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
            wb   <= 1'b0;
            rb   <= 1'b0;
            row  <= 3'd0;
            k    <= 6'd0;
        end else begin
            if (acc) begin
                row <= row + 3'd1;
                if (row == 3'd7) begin
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                end
            end
            if (rd) begin
                k <= k + 6'd1;
                if (rd_done) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                end
            end
        end
    end
endmodule

// File: tb/tb_quant_zigzag.sv
// tb_quant_zigzag: table vectors, directed block sequences and random
// traffic against a block-level quantize/zigzag reference model.
module tb_quant_zigzag;
    localparam int IN_W  = 16;
    localparam int OUT_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [8*IN_W-1:0] in_row = '0;
    logic              qt_we = 1'b0;
    logic [5:0]        qt_addr = '0;
    logic [15:0]       qt_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic [5:0]        out_idx;
    logic              out_last;

    quant_zigzag #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .qt_we(qt_we), .qt_addr(qt_addr), .qt_data(qt_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct { int data; int idx; } exp_t;
    typedef struct { int coeff; int recip; int want; } vec_t;

    exp_t exp_q[$];
    vec_t vecs[12];
    int   tbl[64];
    int   zz[64];
    int   blk[64];
    int   row_n;
    int   blocks_done;
    bit   use_fixed;
    int   fixed_val;
    int   checks;
    int   errors;
    int   cur_recip;
    int   zk;
    int   target;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    function automatic int mquant(input int c, input int r);
        longint p;
        longint v;
        p = longint'(c) * longint'(r);
        if (p >= 0) v = (p + 32768) / 65536;
        else v = -((-p + 32768) / 65536);
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        return int'(v);
    endfunction

    // One cycle: compare outputs against the model, advance the model, wait.
    task automatic tick(output bit acc);
        int   nfull;
        bit   erdy;
        bit   eov;
        exp_t e;
        nfull = (exp_q.size() + 63) / 64;
        erdy = nfull < 2;
        eov = nfull > 0;
        acc = 1'b0;
        chk("in_ready", int'(in_ready), int'(erdy));
        chk("out_valid", int'(out_valid), int'(eov));
        if (eov && out_valid) begin
            chk("out_data", int'($signed(out_data)), exp_q[0].data);
            chk("out_idx", int'(out_idx), exp_q[0].idx);
            chk("out_last", int'(out_last), int'(exp_q[0].idx == 63));
            if (out_ready) void'(exp_q.pop_front());
        end
        if (in_valid && erdy) begin
            acc = 1'b1;
            for (int c = 0; c < 8; c++)
                blk[row_n*8+c] = mquant(int'($signed(in_row[c*IN_W +: IN_W])),
                                        tbl[row_n*8+c]);
            row_n++;
            if (row_n == 8) begin
                for (int i = 0; i < 64; i++) begin
                    e.data = use_fixed ? fixed_val : blk[zz[i]];
                    e.idx = i;
                    exp_q.push_back(e);
                end
                row_n = 0;
                blocks_done++;
            end
        end
        if (qt_we) tbl[qt_addr] = int'(qt_data);
        @(negedge clk);
    endtask

    task automatic step();
        bit a;
        tick(a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        qt_we = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        row_n = 0;
        cur_recip = 4096;
        foreach (tbl[i]) tbl[i] = 4096;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_data", int'(out_data), 0);
    endtask

    task automatic send_row(input int base, input int step_v);
        bit a;
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++)
            in_row[c*IN_W +: IN_W] = IN_W'(base + step_v*c);
        for (int i = 0; i < 300 && !done; i++) begin
            tick(a);
            done = a;
            qt_we = 1'b0;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic fill_tbl(input int v);
        qt_we = 1'b1;
        for (int a = 0; a < 64; a++) begin
            qt_addr = 6'(a);
            qt_data = 16'(v);
            step();
        end
        qt_we = 1'b0;
        cur_recip = v;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) step();
        chk("drain_left", exp_q.size(), 0);
        step();
    endtask

    task automatic rand_row();
        for (int c = 0; c < 8; c++) begin
            if ($urandom % 2 == 0)
                in_row[c*IN_W +: IN_W] = IN_W'($urandom);
            else
                in_row[c*IN_W +: IN_W] = IN_W'(int'($urandom_range(600)) - 300);
        end
    endtask

    initial begin
        vecs[0]  = '{160, 4096, 10};
        vecs[1]  = '{-24, 4096, -2};
        vecs[2]  = '{8, 4096, 1};
        vecs[3]  = '{3, 32768, 2};
        vecs[4]  = '{-3, 32768, -2};
        vecs[5]  = '{2, 32768, 1};
        vecs[6]  = '{1, 32768, 1};
        vecs[7]  = '{-1, 32768, -1};
        vecs[8]  = '{32767, 65535, 2047};
        vecs[9]  = '{-32768, 65535, -2048};
        vecs[10] = '{160, 65535, 160};
        vecs[11] = '{1234, 0, 0};

        zk = 0;
        for (int s = 0; s < 15; s++) begin
            for (int i = 0; i <= s; i++) begin
                int r;
                int c;
                r = (s % 2 == 1) ? i : s - i;
                c = s - r;
                if (r < 8 && c < 8) begin
                    zz[zk] = r*8 + c;
                    zk++;
                end
            end
        end

        checks = 0;
        errors = 0;
        blocks_done = 0;
        use_fixed = 1'b0;
        fixed_val = 0;
        do_reset();

        foreach (vecs[v]) begin
            if (vecs[v].recip != cur_recip) fill_tbl(vecs[v].recip);
            use_fixed = 1'b1;
            fixed_val = vecs[v].want;
            out_ready = 1'b1;
            for (int r = 0; r < 8; r++) send_row(vecs[v].coeff, 0);
            drain();
            use_fixed = 1'b0;
        end

        fill_tbl(65535);
        for (int r = 0; r < 8; r++) send_row(r*8, 1);
        drain();

        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int r = 0; r < 17; r++) begin
            rand_row();
            if (r == 16) chk("row17_blocked", int'(in_ready), 0);
            step();
        end
        in_valid = 1'b0;
        drain();

        fill_tbl(4096);
        out_ready = 1'b1;
        qt_we = 1'b1;
        qt_addr = 6'd0;
        qt_data = 16'hFFFF;
        send_row(160, 0);
        for (int r = 1; r < 16; r++) send_row(160, 0);
        drain();

        out_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            rand_row();
            in_valid = 1'b1;
            step();
        end
        do_reset();
        use_fixed = 1'b1;
        fixed_val = 10;
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) send_row(160, 0);
        drain();
        use_fixed = 1'b0;
        for (int i = 0; i < 4; i++) step();

        target = blocks_done + 6;
        for (int cyc = 0; cyc < 4000 && blocks_done < target; cyc++) begin
            in_valid = ($urandom % 4) != 0;
            rand_row();
            out_ready = ($urandom % 3) != 0;
            qt_we = ($urandom % 8) == 0;
            qt_addr = 6'($urandom);
            qt_data = 16'($urandom);
            step();
        end
        in_valid = 1'b0;
        qt_we = 1'b0;
        chk("rand_blocks", blocks_done, target);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/quant_zigzag.md
QUANT_ZIGZAG -- requirements
Module: quant_zigzag

Interface
REQ-001 SHALL have parameter IN_W, default 16, signed DCT coefficient width per lane.
REQ-002 SHALL have parameter OUT_W, default 12, signed quantized coefficient width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  in_row holds one 2D-DCT output row.
REQ-007 in_ready  output  1  block accepts a row this cycle.
REQ-008 in_row  input  8*IN_W  eight signed coefficients; lane c (column c) at bits [c*IN_W +: IN_W].
REQ-009 qt_we  input  1  reciprocal table write strobe.
REQ-010 qt_addr  input  6  table address, raster order (row*8+col).
REQ-011 qt_data  input  16  unsigned Q0.16 reciprocal (AAN scale folded in).
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_data  output  OUT_W  quantized coefficient, zigzag order.
REQ-015 out_idx  output  6  zigzag position of out_data (0..63).
REQ-016 out_last  output  1  high with out_idx==63.

Function
REQ-017 Row accepted on rising clk when in_valid && in_ready; rows of a block arrive in order 0..7, tracked by 3-bit row counter.
REQ-018 Per lane on acceptance: p = coeff(IN_W signed) * recip(16 unsigned), full precision; q = p/2^16 rounded half away from zero; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-019 All 8 lanes quantized combinationally and written into current write bank at raster addresses row*8+0..7 on the accepting edge.
REQ-020 Two 64 x OUT_W banks, each state EMPTY or FULL; write pointer wb and read pointer rb (1 bit each).
REQ-021 Bank wb goes EMPTY->FULL on acceptance of row 7; wb toggles; row counter wraps to 0.
REQ-022 in_ready = (bank wb is EMPTY).
REQ-023 out_valid = (bank rb is FULL); out_data = bank rb at raster address zz(k), k = 6-bit read counter, zz = standard JPEG zigzag table (0,1,8,16,9,2,3,10,17,24,...,63).
REQ-024 out_idx = k; out_last = out_valid && k==63.
REQ-025 On out_valid && out_ready: k increments; at k==63, k wraps to 0, bank rb FULL->EMPTY, rb toggles.
REQ-026 Latency: first out_valid in cycle immediately after edge accepting row 7 (when other bank not draining ahead of it).
REQ-027 Simultaneous row-7 accept into one bank and final read of other bank SHALL both take effect on the same edge.
REQ-028 in_ready SHALL rise the cycle after the final read (k==63) of the bank it waits on.
REQ-029 out_data/out_idx SHALL hold stable while out_valid && !out_ready.
REQ-030 Table write (qt_we) updates entry qt_addr on rising edge; a row accepted on the same edge uses the old value; written value applies to all later rows.

Reset
REQ-031 On rst: in_ready=1, out_valid=0, out_last=0, out_idx=0, out_data=0, wb=rb=0, row counter=0, k=0, both banks EMPTY.
REQ-032 On rst: all 64 table entries SHALL reset to 16'd4096 (x1/16).
REQ-033 Reset mid-block SHALL discard partial and completed-but-unread blocks; no output from pre-reset data after release.

Verification
REQ-034 Reset release -> in_ready=1, out_valid=0, out_last=0, out_idx=0.
REQ-035 Table all 65535, 8 rows with coeff = raster index (0..63), out_ready=1 -> out_data sequence 0,1,8,16,9,2,3,10,17,24,... 63 over 64 cycles; out_last only on 64th.
REQ-036 Rounding/saturation, table 32768: coeff 3 -> 2, -3 -> -2, 2 -> 1; table 65535: 32767 -> 2047, -32768 -> -2048.
REQ-037 out_ready=0, push 16 rows continuously -> all accepted, 17th row sees in_ready=0; set out_ready=1 -> in_ready rises cycle after 64th output of block 0; block 1 follows without gap.
REQ-038 Accept 5 rows, pulse rst, send 8 new rows of 160 (default table) -> exactly 64 outputs all 10, no stale data.
REQ-039 qt_we to addr 0 with 65535 on same edge as row 0 (coeff 160) -> out_data[0]=10; next block's index 0 with coeff 160 -> 160 saturating-free (160).
